element_sumtree: RTL

- Parametrised successor to the fixed 4/8-way element summers. Combines NELEM element output streams (NSLICE 16-bit I/Q samples per clock each) into one DAC-side stream.
- Uses a registered binary adder tree with a per-element enable mask, selectable saturate/wrap, and sticky overflow status with a saturating counter.
- Sits between the element generators and the DAC output mux.

---
 rtl/elem_pkg.sv | 34 +++
 rtl/sumtree_slice.sv | 62 ++++++
 rtl/element_sumtree.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/elem_pkg.sv
// Shared definitions for the element summing path: sample width, slice
// packing offsets and the int16 saturation helper.
package elem_pkg;

  localparam int SAMPLE_W = 16;
  // Working width used when handing a tree sum to sat16; wide enough for
  // any tree width (16 + log2(16) = 20 bits).
  localparam int CALC_W   = 32;

  typedef struct packed {
    logic                ovf;
    logic [SAMPLE_W-1:0] val;
  } sat_t;

  // Bit offset of element e, slice s inside a packed element bus.
  function automatic int slice_off(input int e, input int s, input int nslice);
    return (e * nslice + s) * SAMPLE_W;
  endfunction

  // Reduce a sign-extended tree sum to one int16 sample. The overflow flag is
  // always reported; the value is clamped only when saturate is set,
  // otherwise it is the low 16 bits (wrap).
  function automatic sat_t sat16(input logic signed [CALC_W-1:0] sum,
                                 input logic                     saturate);
    sat_t r;
    r.ovf = (sum > 32'sd32767) || (sum < -32'sd32768);
    r.val = sum[SAMPLE_W-1:0];
    if (saturate && r.ovf) begin
      r.val = sum[CALC_W-1] ? 16'h8000 : 16'h7FFF;
    end
    return r;
  endfunction

endpackage

// File: rtl/sumtree_slice.sv
// Registered binary adder tree for one slice of one component (I or Q).
// Leaves beyond NELEM are padded with zero up to the next power of two; each
// tree level is one register stage, so the root lags the leaves by
// log2(NELEM) clocks. With a single element the leaf passes straight through.
module sumtree_slice
  import elem_pkg::*;
#(
  parameter int NELEM = 8,
  parameter int W     = SAMPLE_W + 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NELEM*W-1:0]     leaves,
  output logic signed [W-1:0]    sum
);

  localparam int LOG2N = $clog2(NELEM);
  localparam int NPAD  = 1 << LOG2N;

  logic signed [W-1:0] leaf [NPAD];

  for (genvar i = 0; i < NPAD; i++) begin : g_leaf
    if (i < NELEM) begin : g_real
      assign leaf[i] = leaves[i*W +: W];
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  if (NPAD == 1) begin : g_flat
    assign sum = leaf[0];
  end else begin : g_tree
    // Heap-ordered internal nodes: node 1 is the root, node n has children
    // 2n and 2n+1; indices at or above NPAD refer to leaves.
    logic signed [W-1:0] node [1:NPAD-1];

    for (genvar n = 1; n < NPAD; n++) begin : g_node
      logic signed [W-1:0] lhs;
      logic signed [W-1:0] rhs;

      if (2*n < NPAD) begin : g_inner
        assign lhs = node[2*n];
        assign rhs = node[2*n+1];
      end else begin : g_bottom
        assign lhs = leaf[2*n-NPAD];
        assign rhs = leaf[2*n+1-NPAD];
      end

      // One pairwise sum per node; W bits cannot overflow for NELEM inputs.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          node[n] <= '0;
        end else begin
          node[n] <= lhs + rhs;
        end
      end
    end

    assign sum = node[1];
  end

endmodule

// File: rtl/element_sumtree.sv
// Combines NELEM element streams into one DAC-side stream: masks and
// sign-extends the inputs, sums them through per-slice adder trees, then
// saturates or wraps each slice and tracks overflow status.
module element_sumtree
  import elem_pkg::*;
#(
  parameter int NELEM    = 8,
  parameter int NSLICE   = 4,
  parameter int SATURATE = 1
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [NELEM-1:0]                   valid_in,
  input  logic [NELEM*NSLICE*SAMPLE_W-1:0]   multix_in,
  input  logic [NELEM*NSLICE*SAMPLE_W-1:0]   multiy_in,
  input  logic [NELEM-1:0]                   enable,
  input  logic                               ovf_clr,
  output logic                               valid,
  output logic [NSLICE*SAMPLE_W-1:0]         multix,
  output logic [NSLICE*SAMPLE_W-1:0]         multiy,
  output logic [NELEM-1:0]                   postprobusy,
  output logic [1:0]                         ovf_sticky,
  output logic [15:0]                        ovf_count
);

  localparam int   LOG2N  = $clog2(NELEM);
  localparam int   W      = SAMPLE_W + LOG2N;
  localparam int   LAT    = LOG2N + 2;
  localparam logic SAT_EN = (SATURATE != 0);

  logic [NELEM*W-1:0]  s0_x  [NSLICE];
  logic [NELEM*W-1:0]  s0_y  [NSLICE];
  logic signed [W-1:0] sum_x [NSLICE];
  logic signed [W-1:0] sum_y [NSLICE];
  sat_t                sat_x [NSLICE];
  sat_t                sat_y [NSLICE];
  logic                ovf_x_any;
  logic                ovf_y_any;
  logic [LAT-1:0]      vpipe;
  logic                v0;
  logic                out_vld;

  assign v0      = |(valid_in & enable);
  assign out_vld = vpipe[LAT-2];
  assign valid   = vpipe[LAT-1];

  // An enabled element stays busy from its own valid until the pipeline is
  // empty, so it cannot be torn down while its last sample is in flight.
  assign postprobusy = enable & (valid_in | {NELEM{|vpipe}});

  // Stage 0: gate each element by its enable in the same cycle and widen it
  // to the tree width so the sums below are exact.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NSLICE; s++) begin
        s0_x[s] <= '0;
        s0_y[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NSLICE; s++) begin
        for (int e = 0; e < NELEM; e++) begin
          s0_x[s][e*W +: W] <= enable[e]
            ? W'($signed(multix_in[slice_off(e, s, NSLICE) +: SAMPLE_W])) : '0;
          s0_y[s][e*W +: W] <= enable[e]
            ? W'($signed(multiy_in[slice_off(e, s, NSLICE) +: SAMPLE_W])) : '0;
        end
      end
    end
  end

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    sumtree_slice #(
      .NELEM (NELEM),
      .W     (W)
    ) u_tree_x (
      .clk    (clk),
      .resetn (resetn),
      .leaves (s0_x[s]),
      .sum    (sum_x[s])
    );

    sumtree_slice #(
      .NELEM (NELEM),
      .W     (W)
    ) u_tree_y (
      .clk    (clk),
      .resetn (resetn),
      .leaves (s0_y[s]),
      .sum    (sum_y[s])
    );
  end

  // Reduce every tree root to int16 and collect per-component overflow.
  always_comb begin
    ovf_x_any = 1'b0;
    ovf_y_any = 1'b0;
    for (int s = 0; s < NSLICE; s++) begin
      sat_x[s]  = sat16(CALC_W'(sum_x[s]), SAT_EN);
      sat_y[s]  = sat16(CALC_W'(sum_y[s]), SAT_EN);
      ovf_x_any = ovf_x_any | sat_x[s].ovf;
      ovf_y_any = ovf_y_any | sat_y[s].ovf;
    end
  end

  // Valid shift register, aligned with the data through every stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vpipe <= '0;
    end else begin
      vpipe <= {vpipe[LAT-2:0], v0};
    end
  end

  // Output stage: data registers load every cycle regardless of valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      multix <= '0;
      multiy <= '0;
    end else begin
      for (int s = 0; s < NSLICE; s++) begin
        multix[s*SAMPLE_W +: SAMPLE_W] <= sat_x[s].val;
        multiy[s*SAMPLE_W +: SAMPLE_W] <= sat_y[s].val;
      end
    end
  end

  // Overflow status; a clear coinciding with an overflow restarts from that
  // event rather than dropping it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_sticky <= 2'b00;
      ovf_count  <= 16'd0;
    end else if (ovf_clr) begin
      ovf_sticky <= out_vld ? {ovf_y_any, ovf_x_any} : 2'b00;
      ovf_count  <= (out_vld && (ovf_x_any || ovf_y_any)) ? 16'd1 : 16'd0;
    end else if (out_vld) begin
      ovf_sticky <= ovf_sticky | {ovf_y_any, ovf_x_any};
      if ((ovf_x_any || ovf_y_any) && (ovf_count != 16'hFFFF)) begin
        ovf_count <= ovf_count + 16'd1;
      end
    end
  end

endmodule
